// File: rtl/crypt_job_scheduler_pkg.sv
// Shared definitions for the crypt job scheduler.
// Contents: default datapath widths, FSM state encodings, datapath mode encodings.
// Optional feature macro used elsewhere in this slice: STATS_EN.
package crypt_job_scheduler_pkg;

    localparam int RAW_W = 60;   // plaintext width
    localparam int ENC_W = 78;   // ciphertext width

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    // Datapath mode; also used as the last-grant encoding (0 = ENC side, 1 = DEC side)
    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/crypt_job_scheduler_if.sv
// Requester-facing channels of the crypt job scheduler.
// Contents: encrypt request/response and decrypt request/response channels.
//   slave  modport: scheduler side (takes requests, drives responses)
//   master modport: requester/consumer side
// Handshake: every channel is valid/ready. A transfer happens on a rising clock
// edge where valid and ready are both high. Once a response valid is raised, its
// data is held stable and valid stays high until that transfer happens.
interface crypt_job_scheduler_if;
    import crypt_job_scheduler_pkg::*;

    logic             enc_req_valid;
    logic             enc_req_ready;
    logic [RAW_W-1:0] enc_req_data;
    logic             enc_rsp_valid;
    logic             enc_rsp_ready;
    logic [ENC_W-1:0] enc_rsp_data;

    logic             dec_req_valid;
    logic             dec_req_ready;
    logic [ENC_W-1:0] dec_req_data;
    logic             dec_rsp_valid;
    logic             dec_rsp_ready;
    logic [RAW_W-1:0] dec_rsp_data;

    modport slave (
        input  enc_req_valid, enc_req_data, enc_rsp_ready,
        input  dec_req_valid, dec_req_data, dec_rsp_ready,
        output enc_req_ready, enc_rsp_valid, enc_rsp_data,
        output dec_req_ready, dec_rsp_valid, dec_rsp_data
    );

    modport master (
        output enc_req_valid, enc_req_data, enc_rsp_ready,
        output dec_req_valid, dec_req_data, dec_rsp_ready,
        input  enc_req_ready, enc_rsp_valid, enc_rsp_data,
        input  dec_req_ready, dec_rsp_valid, dec_rsp_data
    );

endinterface

// File: rtl/crypt_job_scheduler_arb.sv
// crypt_rr_arbiter: combinational 2-way round-robin arbiter.
// Ports:
//   req[1:0]   in   request lines (bit 0 = ENC side, bit 1 = DEC side)
//   lastGrant  in   side granted last (0 = ENC, 1 = DEC); register lives in the caller
//   grant[1:0] out  one-hot grant, all zero when nothing requests
module crypt_rr_arbiter (
    input  logic [1:0] req,
    input  logic       lastGrant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On a tie the side that was not served last wins
        if (req == 2'b11) begin
            grant = lastGrant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/crypt_job_scheduler.sv
// crypt_job_scheduler: shares one encrypt/decrypt core between an encrypt and a
// decrypt requester, one job in flight, round-robin between the two sides.
// Optional feature macro: STATS_EN (adds enc_jobs/dec_jobs completion counters).
// Ports:
//   Clk, Rst_n        clock (rising edge), asynchronous active-low reset
//   bus               requester channels (crypt_job_scheduler_if.slave)
//   dp_start          one-cycle start pulse to the core
//   dp_mode           0 = encrypt, 1 = decrypt
//   dp_in_raw/enc     registered core operands, stable from ISSUE through WAIT
//   dp_out_enc/raw    core results, sampled DP_LAT cycles after dp_start
//   busy              high whenever the FSM is not IDLE
//   dbgState          current FSM state
//   enc_jobs/dec_jobs saturating completed-response counters (STATS_EN only)
module crypt_job_scheduler
    import crypt_job_scheduler_pkg::*;
#(
    parameter int DP_LAT = 4
`ifdef STATS_EN
   ,parameter int CNT_W  = 16
`endif
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    crypt_job_scheduler_if.slave bus,
    output logic                 dp_start,
    output logic                 dp_mode,
    output logic [RAW_W-1:0]     dp_in_raw,
    output logic [ENC_W-1:0]     dp_in_enc,
    input  logic [ENC_W-1:0]     dp_out_enc,
    input  logic [RAW_W-1:0]     dp_out_raw,
    output logic                 busy,
    output logic [1:0]           dbgState
`ifdef STATS_EN
   ,output logic [CNT_W-1:0]     enc_jobs
   ,output logic [CNT_W-1:0]     dec_jobs
`endif
);

    localparam int              LAT_W    = $clog2(DP_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(DP_LAT - 1);

    logic [1:0]       stateQ;
    logic             modeQ;
    logic             lastGrantQ;
    logic [LAT_W-1:0] cntQ;
    logic [RAW_W-1:0] rawOpQ;
    logic [ENC_W-1:0] encOpQ;
    logic [ENC_W-1:0] encResQ;
    logic [RAW_W-1:0] rawResQ;
    logic [1:0]       grant;
    logic             isIdle;
    logic             isResp;
    logic             accept;
    logic             rspDone;

    crypt_rr_arbiter uArb (
        .req       ({bus.dec_req_valid, bus.enc_req_valid}),
        .lastGrant (lastGrantQ),
        .grant     (grant)
    );

    assign isIdle = (stateQ == ST_IDLE);
    assign isResp = (stateQ == ST_RESP);

    // Grant already implies the matching valid, so ready only rises for a live request
    assign bus.enc_req_ready = isIdle & grant[0];
    assign bus.dec_req_ready = isIdle & grant[1];
    assign accept            = bus.enc_req_ready | bus.dec_req_ready;

    assign bus.enc_rsp_valid = isResp & (modeQ == MODE_ENC);
    assign bus.dec_rsp_valid = isResp & (modeQ == MODE_DEC);
    assign bus.enc_rsp_data  = encResQ;
    assign bus.dec_rsp_data  = rawResQ;
    assign rspDone = (bus.enc_rsp_valid & bus.enc_rsp_ready) |
                     (bus.dec_rsp_valid & bus.dec_rsp_ready);

    assign dp_start  = (stateQ == ST_ISSUE);
    assign dp_mode   = modeQ;
    assign dp_in_raw = rawOpQ;
    assign dp_in_enc = encOpQ;
    assign busy      = !isIdle;
    assign dbgState  = stateQ;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stateQ     <= ST_IDLE;
            modeQ      <= MODE_ENC;
            lastGrantQ <= MODE_DEC;   // ENC wins the first tie
            cntQ       <= '0;
            rawOpQ     <= '0;
            encOpQ     <= '0;
            encResQ    <= '0;
            rawResQ    <= '0;
        end else begin
            case (stateQ)
                ST_IDLE: begin
                    if (accept) begin
                        modeQ      <= grant[1];
                        lastGrantQ <= grant[1];
                        rawOpQ     <= grant[1] ? '0 : bus.enc_req_data;
                        encOpQ     <= grant[1] ? bus.dec_req_data : '0;
                        stateQ     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cntQ   <= LAT_LOAD;
                    stateQ <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Count reaches 0 in the cycle the core result becomes valid
                    if (cntQ == '0) begin
                        if (modeQ == MODE_DEC) begin
                            rawResQ <= dp_out_raw;
                        end else begin
                            encResQ <= dp_out_enc;
                        end
                        stateQ <= ST_RESP;
                    end else begin
                        cntQ <= cntQ - 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rspDone) begin
                        stateQ <= ST_IDLE;
                    end
                end
                default: stateQ <= ST_IDLE;
            endcase
        end
    end

`ifdef STATS_EN
    logic [CNT_W-1:0] encJobsQ;
    logic [CNT_W-1:0] decJobsQ;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            encJobsQ <= '0;
            decJobsQ <= '0;
        end else if (rspDone) begin
            if (modeQ == MODE_DEC) begin
                if (decJobsQ != '1) decJobsQ <= decJobsQ + 1'b1;
            end else begin
                if (encJobsQ != '1) encJobsQ <= encJobsQ + 1'b1;
            end
        end
    end

    assign enc_jobs = encJobsQ;
    assign dec_jobs = decJobsQ;
`endif

endmodule
